// File: rtl/jtag_user_func_ctrl.sv
// Function-select controller for a shared BSCAN USER chain: an instruction scan latches a code,
// the following data scan is steered to the selected user register.
module jtag_user_func_ctrl #(
  parameter int unsigned     NREG     = 4,
  parameter int unsigned     FW       = 4,
  parameter logic [NREG-1:0] CAP_MASK = 4'b0011
) (
  input  logic            DRCK,
  input  logic            RST,
  input  logic            SEL,
  input  logic            TDI,
  input  logic            SHIFT,
  input  logic            CAPTURE,
  input  logic            UPDATE,
  input  logic [NREG-1:0] REG_TDO,
  output logic            TDO,
  output logic [NREG-1:0] FSEL,
  output logic            FCAP,
  output logic            FSH,
  output logic [FW-1:0]   FUNC,
  output logic            ERR
);

  localparam int unsigned CW = $clog2(FW + 2);

  typedef enum logic {StInstr, StData} state_e;

  state_e          state_q, state_d;
  logic [FW-1:0]   sr_q, sr_d;
  logic [FW-1:0]   func_q, func_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            err_q, err_d;
  logic [NREG-1:0] fsel_q, fsel_d;
  logic            fcap_q, fcap_d;
  logic            fsh_q, fsh_d;
  logic [NREG-1:0] code_dec;
  logic            code_ok;

  // Decoding the shift register directly also yields the range check: 1 <= sr <= NREG.
  always_comb begin
    code_dec = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      code_dec[i] = (sr_q == FW'(i + 1));
    end
    code_ok = |code_dec;
  end

  always_ff @(posedge DRCK) begin
    if (RST) begin
      state_q <= StInstr;
      sr_q    <= '0;
      func_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      fsel_q  <= '0;
      fcap_q  <= 1'b0;
      fsh_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      func_q  <= func_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fsel_q  <= fsel_d;
      fcap_q  <= fcap_d;
      fsh_q   <= fsh_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    func_d  = func_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fsel_d  = fsel_q;
    fcap_d  = fcap_q;
    fsh_d   = fsh_q;
    if (SEL) begin
      case (state_q)
        StInstr: begin
          if (UPDATE) begin
            if (cnt_q == CW'(FW)) begin
              func_d = sr_q;
              if (code_ok) begin
                state_d = StData;
                fsel_d  = code_dec;
                fcap_d  = |(code_dec & CAP_MASK);
                fsh_d   = |(code_dec & ~CAP_MASK);
              end else if (sr_q == '0) begin
                err_d = 1'b0;
              end
            end else begin
              err_d = 1'b1;
            end
          end else if (CAPTURE) begin
            sr_d  = func_q;
            cnt_d = '0;
          end else if (SHIFT) begin
            sr_d = FW'({TDI, sr_q} >> 1);
            if (cnt_q != CW'(FW + 1)) begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        StData: begin
          // Data bits are not counted; the register's own scan owns CAPTURE/SHIFT.
          if (UPDATE) begin
            state_d = StInstr;
            cnt_d   = '0;
            fsel_d  = '0;
            fcap_d  = 1'b0;
            fsh_d   = 1'b0;
          end
        end
        default: state_d = StInstr;
      endcase
    end
  end

  always_comb begin
    TDO = 1'b0;
    if (SEL) begin
      TDO = (state_q == StData) ? |(REG_TDO & fsel_q) : sr_q[0];
    end
  end

  assign FSEL = fsel_q;
  assign FCAP = fcap_q;
  assign FSH  = fsh_q;
  assign FUNC = func_q;
  assign ERR  = err_q;

endmodule

// File: doc/jtag_user_func_ctrl.md
Name: jtag_user_func_ctrl

Overview:
Function-select controller for one BSCAN USER chain that is shared by several parallel-capture/serial-shift user registers.
- A scan through the chain first loads a function code (instruction phase).
- The next data scan is steered to the selected user register: the controller drives its select and capture/shift-only flags and multiplexes its TDO back onto the chain.
- The block sits between the BSCAN primitive outputs and the bank of user registers in the JTAG subsystem.

Parameters:
NREG, 4, number of user registers served (1..15)
FW, 4, function code width in bits; 2**FW must exceed NREG
CAP_MASK, 4'b0011, NREG bits; bit i = 1 means register i is used in capture mode (FCAP), 0 means shift-only (FSH)

Ports:
DRCK  input  1  JTAG data clock from BSCAN; all logic is on its rising edge
RST  input  1  synchronous reset, active-high
SEL  input  1  BSCAN select for this USER chain
TDI  input  1  serial data in
SHIFT  input  1  BSCAN Shift-DR state
CAPTURE  input  1  BSCAN Capture-DR state
UPDATE  input  1  BSCAN Update-DR state
REG_TDO  input  NREG  serial outputs of the user registers
TDO  output  1  serial data out to BSCAN
FSEL  output  NREG  one-hot register select, to the SEL input of each user register
FCAP  output  1  capture-mode flag to the user registers
FSH  output  1  shift-only-mode flag to the user registers
FUNC  output  FW  currently latched function code
ERR  output  1  sticky length-error flag

Behaviour:
- Reset (RST=1 at a DRCK edge), applied regardless of SEL:
  - state=INSTR; shift register (sr) and FUNC = 0; bit counter (cnt) = 0; ERR = 0.
  - FSEL = 0, FCAP = 0, FSH = 0, TDO = 0.
  - A reset during DATA aborts the selection at that same edge.
- Every input event is qualified by SEL. When SEL=0 nothing changes and TDO=0.
- Event priority within one edge: UPDATE > CAPTURE > SHIFT.
- State INSTR:
  - CAPTURE: sr <= {FUNC} (echo of the last code); cnt <= 0.
  - SHIFT: sr <= {TDI, sr[FW-1:1]}, LSB first; cnt increments and saturates at FW+1.
  - TDO = sr[0].
  - UPDATE with cnt==FW: FUNC <= sr.
    - If 1 <= sr <= NREG: go to DATA.
    - Otherwise (code 0 or > NREG): no-op, stay in INSTR.
  - UPDATE with cnt!=FW: ERR <= 1; FUNC unchanged; stay in INSTR.
- State DATA:
  - Outputs are registered and valid from the first edge after the entering UPDATE:
    - FSEL = one-hot bit (FUNC-1).
    - FCAP = CAP_MASK[FUNC-1].
    - FSH = ~CAP_MASK[FUNC-1].
  - TDO = |(REG_TDO & FSEL), combinational.
  - CAPTURE and SHIFT are passed through untouched; the controller does not count data bits.
  - UPDATE: FSEL, FCAP and FSH go to 0 at that edge; state goes to INSTR; cnt <= 0.
  - Each function code therefore covers exactly one data scan.
- ERR clears only on RST, or on a valid-length instruction UPDATE with code 0 (a "clear" no-op).
- FSEL is never multi-hot. FCAP and FSH are never both 1, and both are 0 outside DATA.

Test Plan:
- Reset: assert RST for 2 DRCK edges → FSEL=0, FCAP=0, FSH=0, FUNC=0, ERR=0, TDO=0.
- Capture select: shift 4 bits of code 1 (TDI 1,0,0,0), then UPDATE → next edge FSEL=4'b0001, FCAP=1, FSH=0, FUNC=1. Then CAPTURE + 8 SHIFTs with REG_TDO[0] toggling → TDO mirrors REG_TDO[0]. Then UPDATE → FSEL=0, state INSTR.
- Shift-only select: load code 3, then UPDATE → FSEL=4'b0100, FSH=1, FCAP=0. REG_TDO=4'b1011 → TDO=0; REG_TDO=4'b0100 → TDO=1.
- Length error: shift 3 bits (or 6 bits), then UPDATE → ERR=1, FUNC unchanged, FSEL=0. A later correct 4-bit shift of code 0 with UPDATE → ERR=0.
- Invalid code / SEL gating: code 9 with UPDATE → FUNC=9, FSEL=0, stays in INSTR. SHIFT/UPDATE pulses with SEL=0 → no change in cnt, FUNC or state.
- Reset mid-DATA plus echo: code 2 active (FSEL=4'b0010), assert RST during SHIFT → FSEL=0 at that edge. After reload of code 2, an instruction CAPTURE followed by 4 SHIFTs → TDO sequence 0,1,0,0.
